// File: rtl/sf_input_pkg.sv
// Shared constants and types for the input controller: PS/2 scan codes,
// udlrtsc bit positions, coin FSM state encoding and the key-latch bundle.
package sf_input_pkg;

  // Direction keys: only the low 8 bits are compared, so the E0-extended
  // (bit 8 set) and plain variants both select the same latch.
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Function keys: all 9 bits must match.
  localparam logic [8:0] SC_TRIG   = 9'h014;
  localparam logic [8:0] SC_F1     = 9'h005;
  localparam logic [8:0] SC_F2     = 9'h006;
  localparam logic [8:0] SC_START1 = 9'h016;
  localparam logic [8:0] SC_START2 = 9'h01E;
  localparam logic [8:0] SC_COIN   = 9'h02E;

  // Bit positions inside udlrtsc.
  localparam int UD_UP    = 6;
  localparam int UD_DOWN  = 5;
  localparam int UD_LEFT  = 4;
  localparam int UD_RIGHT = 3;
  localparam int UD_TRIG  = 2;
  localparam int UD_START = 1;
  localparam int UD_COIN  = 0;

  typedef enum logic [1:0] {
    COIN_IDLE     = 2'd0,
    COIN_HOLD     = 2'd1,
    COIN_WAIT_REL = 2'd2,
    COIN_GAP      = 2'd3
  } coin_state_e;

  // One latch per mapped key, loaded with the "pressed" flag on each event.
  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic trig;
    logic f1;
    logic f2;
    logic start1;
    logic start2;
    logic coin;
  } key_latch_t;

endpackage

// File: rtl/sf_coin_stretch.sv
// Coin pulse stretcher: turns any coin_raw rising edge into a coin pulse at
// least COIN_MIN_FRAMES frame ticks long, held further while coin_raw stays
// high, followed by a one-tick guard gap. Edges outside IDLE are dropped.
module sf_coin_stretch
  import sf_input_pkg::*;
#(
  parameter int COIN_MIN_FRAMES = 4
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic frame_tick,
  input  logic coin_raw,
  output logic coin
);

  localparam logic [3:0] C_MIN = 4'(COIN_MIN_FRAMES);

  coin_state_e r_state;
  coin_state_e w_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic        r_coin_raw_d;
  logic        r_coin;
  logic        w_rise;

  assign w_rise = coin_raw & ~r_coin_raw_d;

  // Next-state and counter logic for the coin FSM.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      COIN_IDLE: begin
        // A tick coinciding with the edge is not counted: the load wins.
        if (w_rise) begin
          w_next     = COIN_HOLD;
          w_cnt_next = C_MIN;
        end
      end
      COIN_HOLD: begin
        if (frame_tick) begin
          if (r_cnt <= 4'd1) begin
            w_cnt_next = 4'd0;
            w_next     = coin_raw ? COIN_WAIT_REL : COIN_GAP;
          end else begin
            w_cnt_next = r_cnt - 4'd1;
          end
        end
      end
      COIN_WAIT_REL: begin
        if (!coin_raw) w_next = COIN_GAP;
      end
      COIN_GAP: begin
        if (frame_tick) w_next = COIN_IDLE;
      end
      default: w_next = COIN_IDLE;
    endcase
  end

  // State, counter, edge register and registered coin output.
  always_ff @(posedge clk_sys or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_state      <= COIN_IDLE;
      r_cnt        <= 4'd0;
      r_coin_raw_d <= 1'b1;
      r_coin       <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= w_cnt_next;
      r_coin_raw_d <= coin_raw;
      r_coin       <= (w_next == COIN_HOLD) || (w_next == COIN_WAIT_REL);
    end
  end

  assign coin = r_coin;

endmodule

// File: rtl/sf_input_ctrl.sv
// Input controller: decodes PS/2 key events into key latches, merges them
// with two joypads and drives the registered udlrtsc vector. The coin bit is
// stretched by sf_coin_stretch. Optional autofire is enabled by defining the
// macro SF_AUTOFIRE_EN.
module sf_input_ctrl
  import sf_input_pkg::*;
#(
  parameter int COIN_MIN_FRAMES = 4,
  parameter int AUTOFIRE_FRAMES = 3
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystk1,
  input  logic [15:0] joystk2,
  input  logic        vblank,
  output logic [6:0]  udlrtsc
);

  logic       r_ps2_tog;
  logic       r_armed;
  key_latch_t r_keys;
  key_latch_t w_keys_next;
  logic       r_vblank_d;
  logic       r_frame_tick;
  logic [6:1] r_out;
  logic       w_event;
  logic [8:0] w_code;
  logic       w_pressed;
  logic       w_af_phase;
  logic       w_up, w_down, w_left, w_right, w_trig;
  logic       w_start1, w_start2, w_coin_raw, w_coin;

  assign w_code    = ps2_key[8:0];
  assign w_pressed = ps2_key[9];
  // r_armed blocks decoding on the first cycle out of reset, when the toggle
  // register is only capturing the current ps2_key[10] level.
  assign w_event   = r_armed & (ps2_key[10] ^ r_ps2_tog);

  // Key latch update on a PS/2 event; unmapped codes leave all latches alone.
  always_comb begin
    w_keys_next = r_keys;
    if (w_event) begin
      if (w_code[7:0] == SC_UP)    w_keys_next.up     = w_pressed;
      if (w_code[7:0] == SC_DOWN)  w_keys_next.down   = w_pressed;
      if (w_code[7:0] == SC_LEFT)  w_keys_next.left   = w_pressed;
      if (w_code[7:0] == SC_RIGHT) w_keys_next.right  = w_pressed;
      if (w_code == SC_TRIG)       w_keys_next.trig   = w_pressed;
      if (w_code == SC_F1)         w_keys_next.f1     = w_pressed;
      if (w_code == SC_F2)         w_keys_next.f2     = w_pressed;
      if (w_code == SC_START1)     w_keys_next.start1 = w_pressed;
      if (w_code == SC_START2)     w_keys_next.start2 = w_pressed;
      if (w_code == SC_COIN)       w_keys_next.coin   = w_pressed;
    end
  end

  // PS/2 toggle tracking, key latches and frame-tick generation.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_ps2_tog    <= 1'b0;
      r_armed      <= 1'b0;
      r_keys       <= '0;
      r_vblank_d   <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_ps2_tog    <= ps2_key[10];
      r_armed      <= 1'b1;
      r_keys       <= w_keys_next;
      r_vblank_d   <= vblank;
      r_frame_tick <= vblank & ~r_vblank_d;
    end
  end

`ifdef SF_AUTOFIRE_EN
  logic [3:0] r_af_cnt;
  logic       r_af_toggle;

  // Phase is high from the first held cycle and flips every
  // AUTOFIRE_FRAMES ticks; releasing the button clears everything.
  assign w_af_phase = joystk1[5] & ~r_af_toggle;

  // Autofire tick counter and phase toggle.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_af_cnt    <= 4'd0;
      r_af_toggle <= 1'b0;
    end else if (!joystk1[5]) begin
      r_af_cnt    <= 4'd0;
      r_af_toggle <= 1'b0;
    end else if (r_frame_tick) begin
      if (r_af_cnt == 4'(AUTOFIRE_FRAMES - 1)) begin
        r_af_cnt    <= 4'd0;
        r_af_toggle <= ~r_af_toggle;
      end else begin
        r_af_cnt <= r_af_cnt + 4'd1;
      end
    end
  end

  logic w_unused;
  assign w_unused = ^{joystk1[15:9], joystk2[15:8], joystk2[5:0]};
`else
  assign w_af_phase = 1'b0;

  logic w_unused;
  assign w_unused = ^{joystk1[15:9], joystk1[5], joystk2[15:8], joystk2[5:0],
                      4'(AUTOFIRE_FRAMES)};
`endif

  assign w_up       = r_keys.up    | joystk1[3];
  assign w_down     = r_keys.down  | joystk1[2];
  assign w_left     = r_keys.left  | joystk1[1];
  assign w_right    = r_keys.right | joystk1[0];
  assign w_trig     = r_keys.trig  | joystk1[4] | w_af_phase;
  assign w_start1   = r_keys.f1 | r_keys.start1 | joystk1[6] | joystk2[6];
  assign w_start2   = r_keys.f2 | r_keys.start2 | joystk1[7] | joystk2[7];
  assign w_coin_raw = r_keys.f1 | r_keys.coin | joystk1[8];

  sf_coin_stretch #(
    .COIN_MIN_FRAMES(COIN_MIN_FRAMES)
  ) u_coin (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .frame_tick(r_frame_tick),
    .coin_raw  (w_coin_raw),
    .coin      (w_coin)
  );

  // One-cycle output register for the merged direction/trigger/start bits.
  // start2 has no slot of its own in udlrtsc and shares the start bit.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_out <= '0;
    end else begin
      r_out[UD_UP]    <= w_up;
      r_out[UD_DOWN]  <= w_down;
      r_out[UD_LEFT]  <= w_left;
      r_out[UD_RIGHT] <= w_right;
      r_out[UD_TRIG]  <= w_trig;
      r_out[UD_START] <= w_start1 | w_start2;
    end
  end

  assign udlrtsc = {r_out, w_coin};

endmodule
